// File: rtl/acorn_state_core.sv
// ACORN-128 state core: applies StateUpdate128 once per accepted (m, ca, cb) step
// and tracks initialization. Define ACORN_CT_OUT_EN to add the registered ct_out bit.
module acorn_state_core #(
    parameter int INIT_STEPS = 1792,
    parameter int CNT_W      = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    input  logic             mbit_in,
    input  logic             ca_in,
    input  logic             cb_in,
    output logic             ks_out,
    output logic             ks_valid,
    output logic             busy,
    output logic             init_done,
    output logic [CNT_W-1:0] step_cnt,
`ifdef ACORN_CT_OUT_EN
    output logic             ct_out,
`endif
    output logic [1:0]       dbg_state,
    output logic [292:0]     dbg_s
);

    // Handshake: a step is taken on a rising clk edge when in_valid=1, start=0 and
    // the FSM is in INIT or READY. There is no ready; every such step is consumed.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_INIT  = 2'd1,
        ST_READY = 2'd2
    } state_t;

    state_t       state_q, state_d;
    logic [292:0] s_q, s_next, t;
    logic         ks_c, f_c, accept;

    function automatic logic maj(input logic x, input logic y, input logic z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

    function automatic logic ch(input logic x, input logic y, input logic z);
        return (x & y) ^ (~x & z);
    endfunction

    assign accept = in_valid && !start && (state_q != ST_IDLE);

    // Each feedback tap reads pre-update S, so the chain can be evaluated in parallel.
    always_comb begin
        t      = s_q;
        t[289] = s_q[289] ^ s_q[235] ^ s_q[230];
        t[230] = s_q[230] ^ s_q[196] ^ s_q[193];
        t[193] = s_q[193] ^ s_q[160] ^ s_q[154];
        t[154] = s_q[154] ^ s_q[111] ^ s_q[107];
        t[107] = s_q[107] ^ s_q[66]  ^ s_q[61];
        t[61]  = s_q[61]  ^ s_q[23]  ^ s_q[0];
        ks_c   = t[12] ^ t[154] ^ maj(t[235], t[61], t[193]) ^ ch(t[230], t[111], t[66]);
        f_c    = t[0] ^ ~t[107] ^ maj(t[244], t[23], t[160]) ^ (ca_in & t[196])
               ^ (cb_in & ks_c) ^ mbit_in;
        s_next = {f_c, t[292:1]};
    end

    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = ST_INIT;
        end else begin
            case (state_q)
                ST_INIT:  if (accept && step_cnt == CNT_W'(INIT_STEPS - 1)) state_d = ST_READY;
                default:  state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            s_q      <= '0;
            step_cnt <= '0;
            ks_out   <= 1'b0;
            ks_valid <= 1'b0;
        end else begin
            state_q <= state_d;
            if (start) begin
                s_q      <= '0;
                step_cnt <= '0;
                ks_valid <= 1'b0;
            end else if (accept) begin
                s_q      <= s_next;
                ks_out   <= ks_c;
                ks_valid <= 1'b1;
                if (step_cnt != '1) step_cnt <= step_cnt + 1'b1;
            end else begin
                ks_valid <= 1'b0;
            end
        end
    end

`ifdef ACORN_CT_OUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)         ct_out <= 1'b0;
        else if (accept) ct_out <= mbit_in ^ ks_c;
    end
`endif

    assign busy      = (state_q == ST_INIT);
    assign init_done = (state_q == ST_READY);
    assign dbg_state = state_q;
    assign dbg_s     = s_q;

endmodule

// File: tb/tb_acorn_state_core.sv
// Randomized bench for acorn_state_core against a bit-array model of StateUpdate128.
module tb_acorn_state_core;

    localparam int INIT_STEPS = 1792;
    localparam int CNT_W      = 12;
    localparam int CNT_MAX    = (1 << CNT_W) - 1;

    logic             clk, rst, start, in_valid, mbit_in, ca_in, cb_in;
    logic             ks_out, ks_valid, busy, init_done;
    logic [CNT_W-1:0] step_cnt;
    logic [1:0]       dbg_state;
    logic [292:0]     dbg_s;
`ifdef ACORN_CT_OUT_EN
    logic             ct_out;
`endif

    acorn_state_core #(.INIT_STEPS(INIT_STEPS), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
        .mbit_in(mbit_in), .ca_in(ca_in), .cb_in(cb_in),
        .ks_out(ks_out), .ks_valid(ks_valid), .busy(busy), .init_done(init_done),
        .step_cnt(step_cnt),
`ifdef ACORN_CT_OUT_EN
        .ct_out(ct_out),
`endif
        .dbg_state(dbg_state), .dbg_s(dbg_s)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // reference model
    bit [292:0] ms;
    int         m_cnt, m_phase;  // phase 0 idle, 1 init, 2 ready
    bit         m_ks, m_ksv, m_ct;
    logic       exp_q[$];
    int         n_vec, n_miss, ksv_seen;

    task automatic chk(input string tag, input logic [292:0] obs, input logic [292:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit maj3(input bit x, input bit y, input bit z);
        return (int'(x) + int'(y) + int'(z)) >= 2;
    endfunction

    function automatic bit key_bit(input int i);
        return bit'(((i / 8) >> (i % 8)) & 1);
    endfunction

    function automatic bit iv_bit(input int i);
        return bit'(((16 + i / 8) >> (i % 8)) & 1);
    endfunction

    function automatic bit init_m(input int k);
        if (k < 128)  return key_bit(k);
        if (k < 256)  return iv_bit(k - 128);
        if (k == 256) return key_bit(0) ^ 1'b1;
        return key_bit(k % 128);
    endfunction

    task automatic model_edge(input bit st, input bit v, input bit m, input bit ca, input bit cb);
        bit ks, f;
        if (st) begin
            ms = '0; m_cnt = 0; m_ksv = 0; m_phase = 1;
        end else if (v && m_phase != 0) begin
            ms[289] ^= ms[235] ^ ms[230];
            ms[230] ^= ms[196] ^ ms[193];
            ms[193] ^= ms[160] ^ ms[154];
            ms[154] ^= ms[111] ^ ms[107];
            ms[107] ^= ms[66] ^ ms[61];
            ms[61]  ^= ms[23] ^ ms[0];
            ks = ms[12] ^ ms[154] ^ maj3(ms[235], ms[61], ms[193])
               ^ (ms[230] ? ms[111] : ms[66]);
            f  = ms[0] ^ !ms[107] ^ maj3(ms[244], ms[23], ms[160])
               ^ (ca & ms[196]) ^ (cb & ks) ^ m;
            ms = {f, ms[292:1]};
            m_ks = ks; m_ct = m ^ ks; m_ksv = 1;
            exp_q.push_back(ks);
            if (m_cnt < CNT_MAX) m_cnt++;
            if (m_phase == 1 && m_cnt == INIT_STEPS) m_phase = 2;
        end else begin
            m_ksv = 0;
        end
    endtask

    task automatic model_reset();
        ms = '0; m_cnt = 0; m_phase = 0; m_ks = 0; m_ksv = 0; m_ct = 0;
        exp_q.delete();
    endtask

    task automatic check_outputs();
        chk("ks_valid", 293'(ks_valid), 293'(m_ksv));
        chk("step_cnt", 293'(step_cnt), 293'(m_cnt));
        chk("busy", 293'(busy), 293'(m_phase == 1));
        chk("init_done", 293'(init_done), 293'(m_phase == 2));
        chk("state", dbg_s, ms);
        chk("ks_hold", 293'(ks_out), 293'(m_ks));
        if (ks_valid) begin
            ksv_seen++;
            if (exp_q.size() > 0) chk("ks_out", 293'(ks_out), 293'(exp_q.pop_front()));
`ifdef ACORN_CT_OUT_EN
            chk("ct_out", 293'(ct_out), 293'(m_ct));
`endif
        end
    endtask

    // driver: called #1 after an edge; drives, waits for the next edge, then checks
    task automatic apply(input bit st, input bit v, input bit m, input bit ca, input bit cb);
        start = st; in_valid = v; mbit_in = m; ca_in = ca; cb_in = cb;
        @(posedge clk);
        #1;
        model_edge(st, v, m, ca, cb);
        check_outputs();
        start = 1'b0; in_valid = 1'b0;
    endtask

    task automatic run_init(input int steps, input bit gaps);
        int k;
        k = 0;
        while (k < steps) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                apply(0, 0, bit'($urandom_range(0, 1)), 1, 1);
            end else begin
                apply(0, 1, init_m(k), 1, 1);
                k++;
            end
        end
    endtask

    initial begin
        logic [292:0] top_only;
        top_only = '0;
        top_only[292] = 1'b1;
        n_vec = 0; n_miss = 0; ksv_seen = 0;
        rst = 1'b1; start = 0; in_valid = 0; mbit_in = 0; ca_in = 0; cb_in = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_outputs();

        // IDLE ignores steps
        apply(0, 1, 0, 1, 1);
        apply(0, 1, 1, 0, 1);

        // single step from zero, m=0: only s292 becomes 1
        apply(1, 0, 0, 0, 0);
        apply(0, 1, 0, 1, 1);
        chk("one_step_s", dbg_s, top_only);
        chk("one_step_cnt", 293'(step_cnt), 293'd1);

        // single step from zero, m=1: state stays zero
        apply(1, 0, 0, 0, 0);
        apply(0, 1, 1, 1, 1);
        chk("m1_step_s", dbg_s, 293'd0);

        // full initialization with gaps
        apply(1, 0, 0, 0, 0);
        ksv_seen = 0;
        run_init(INIT_STEPS, 1'b1);
        chk("init_ksv_count", 293'(ksv_seen), 293'(INIT_STEPS));
        chk("init_done_end", 293'(init_done), 293'd1);
        chk("init_cnt_end", 293'(step_cnt), 293'(INIT_STEPS));

        // READY random traffic
        repeat (300)
            apply(0, bit'($urandom_range(0, 3) != 0), bit'($urandom_range(0, 1)),
                  bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
        apply(0, 1, 1, 0, 0);
        apply(0, 1, 0, 0, 0);
        apply(0, 1, 1, 0, 0);
        apply(0, 1, 1, 0, 0);

        // start wins over a step offered in READY
        apply(1, 1, 1, 1, 1);
        chk("restart_s", dbg_s, 293'd0);
        chk("restart_busy", 293'(busy), 293'd1);

        // run past saturation of the step counter
        repeat (CNT_MAX + 100)
            apply(0, 1, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
                  bit'($urandom_range(0, 1)));
        chk("sat_cnt", 293'(step_cnt), 293'(CNT_MAX));

        // asynchronous reset at step 900 of INIT
        apply(1, 0, 0, 0, 0);
        run_init(900, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs();
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_outputs();
        repeat (5) apply(0, 1, bit'($urandom_range(0, 1)), 1, 1);
        chk("post_rst_idle_s", dbg_s, 293'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/acorn_state_core.md
Name: acorn_state_core

Overview:
- Consumer end of the ACORN-128 control/message bit stream: takes one (mbit, ca, cb) triple per step and applies StateUpdate128 to the 293-bit ACORN state.
- Counts the initialization steps and flags completion.
- After initialization it keeps stepping on the same stream for associated-data, plaintext and finalization phases, emitting one keystream bit per step.
- Sits directly downstream of the init stream generator and feeds the encrypt/tag logic.

Parameters:
- INIT_STEPS, 1792, number of accepted steps that make up initialization.
- CNT_W, 12, step counter width; must satisfy 2^CNT_W > INIT_STEPS.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  one-cycle pulse: clear state and counter, enter INIT
- in_valid  input  1  the triple on mbit_in/ca_in/cb_in is a step to apply this cycle
- mbit_in  input  1  message bit m
- ca_in  input  1  control bit ca
- cb_in  input  1  control bit cb
- ks_out  output  1  keystream bit of the last applied step (registered)
- ks_valid  output  1  ks_out updated this cycle
- busy  output  1  high in INIT
- init_done  output  1  high in READY (sticky until start or rst)
- step_cnt  output  CNT_W  accepted steps since start, saturating at all-ones

Behaviour:
- Reset values: state S[292:0]=0, FSM=IDLE, step_cnt=0, ks_out=0, ks_valid=0, busy=0, init_done=0.
- FSM states:
  - IDLE: in_valid ignored; start -> INIT.
  - INIT: each in_valid cycle applies one step; the INIT_STEPS-th accepted step -> READY on the same edge.
  - READY: each in_valid applies one step; start -> INIT.
- start, in any state, has priority over in_valid in the same cycle: S=0, step_cnt=0, ks_valid=0, next state INIT; the step offered that cycle is dropped.
- Step function, evaluated on the pre-update S:
  - s289^=s235^s230; s230^=s196^s193; s193^=s160^s154; s154^=s111^s107; s107^=s66^s61; s61^=s23^s0.
  - All following terms use these updated values.
  - ks = s12^s154^maj(s235,s61,s193)^ch(s230,s111,s66).
  - f = s0^~s107^maj(s244,s23,s160)^(ca&s196)^(cb&ks)^m.
  - S shifts down by one (s[j]=s[j+1]); s292=f.
  - maj(x,y,z)=xy^xz^yz; ch(x,y,z)=xy^(~x)z.
- Latency: one cycle. ks_out/ks_valid register on the same edge that updates S.
- ks_valid is high for exactly the cycles after accepted steps, in INIT and READY.
- in_valid low: S, step_cnt and ks_out hold; ks_valid=0.
- step_cnt increments per accepted step and saturates at 2^CNT_W-1; it does not wrap.
- init_done rises on the edge that applies step INIT_STEPS; busy falls on the same edge.
- rst mid-operation: immediate return to reset values; no partial step is retained.
- Input stream alignment: the upstream generator's registered mbit for count k is valid one cycle after count k. The upstream drives in_valid with the same one-cycle delay; this block adds no compensation.

Optional Feature:
- Macro ACORN_CT_OUT_EN.
- Defined: adds output ct_out (1 bit), registered with ks_out, ct_out = mbit_in ^ ks, reset value 0, updated only on accepted steps, valid with ks_valid.
- Undefined: the port and its register are absent; all other behaviour is identical.

Test Plan:
- rst then start, one step m=0, ca=cb=1 -> ks_out=0, ks_valid=1 one cycle, S[292]=1, all other bits 0, step_cnt=1.
- From zero state, one step m=1, ca=cb=1 -> f=0, S stays all-zero, ks_out=0, step_cnt=1.
- start then 1792 in_valid steps, with gaps of in_valid=0 inserted -> init_done rises exactly on accepted step 1792, busy falls on the same edge, step_cnt=1792.
  - Final S matches the golden C model for key=0x00..0F, iv=0x10..1F fed in generator order.
  - ks_valid count equals 1792.
- In READY, pulse start together with in_valid=1 -> S=0, step_cnt=0, busy=1, init_done=0, ks_valid=0 next cycle; that step is not applied.
- Assert rst during INIT at step 900 -> all outputs and S return to 0 asynchronously; in_valid is ignored until the next start.
- With ACORN_CT_OUT_EN defined, in READY feed m=1,0,1,1 -> ct_out equals m^ks_out on each ks_valid cycle; without the macro, the build has no ct_out port.
